// File: rtl/chacha20_core_arbiter_if.sv
// Signal bundle between the ChaCha20 core arbiter and its two keystream
// channels plus the shared block core. The arbiter takes the slave side.
interface chacha20_core_arbiter_if;
  logic         i_ch0_req;
  logic [31:0]  i_ch0_counter;
  logic [95:0]  i_ch0_nonce;
  logic         o_ch0_busy;
  logic [511:0] o_ch0_keystream_data;
  logic         o_ch0_keystream_valid;

  logic         i_ch1_req;
  logic [31:0]  i_ch1_counter;
  logic [95:0]  i_ch1_nonce;
  logic         o_ch1_busy;
  logic [511:0] o_ch1_keystream_data;
  logic         o_ch1_keystream_valid;

  logic         o_core_req;
  logic         i_core_busy;
  logic [31:0]  o_core_counter;
  logic [95:0]  o_core_nonce;
  logic [511:0] i_core_keystream_data;
  logic         i_core_keystream_valid;
  logic         o_error;

  modport slave (
    input  i_ch0_req, i_ch0_counter, i_ch0_nonce,
    output o_ch0_busy, o_ch0_keystream_data, o_ch0_keystream_valid,
    input  i_ch1_req, i_ch1_counter, i_ch1_nonce,
    output o_ch1_busy, o_ch1_keystream_data, o_ch1_keystream_valid,
    output o_core_req, o_core_counter, o_core_nonce, o_error,
    input  i_core_busy, i_core_keystream_data, i_core_keystream_valid
  );

  modport master (
    output i_ch0_req, i_ch0_counter, i_ch0_nonce,
    input  o_ch0_busy, o_ch0_keystream_data, o_ch0_keystream_valid,
    output i_ch1_req, i_ch1_counter, i_ch1_nonce,
    input  o_ch1_busy, o_ch1_keystream_data, o_ch1_keystream_valid,
    input  o_core_req, o_core_counter, o_core_nonce, o_error,
    output i_core_busy, i_core_keystream_data, i_core_keystream_valid
  );
endinterface

// File: rtl/chacha20_core_arbiter.sv
// Round-robin sharing of one ChaCha20 block core between two keystream
// channels, with per-channel request capture and a WAIT-state timeout.
module chacha20_core_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   i_aclk,
  input  logic                   i_aresetn,
  chacha20_core_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t       r_state;
  logic         r_pend0, r_pend1;
  logic [31:0]  r_cnt0, r_cnt1;
  logic [95:0]  r_non0, r_non1;
  logic         r_grant;
  logic         r_last;
  logic [15:0]  r_tmo;
  logic         r_core_req;
  logic [31:0]  r_core_counter;
  logic [95:0]  r_core_nonce;
  logic [511:0] r_data;
  logic         r_valid0, r_valid1;
  logic         r_error;

  logic         w_busy0, w_busy1;
  logic         w_pick;
  logic [15:0]  w_tmo_next;

  // A channel is busy from capture until its block is delivered or aborted.
  assign w_busy0    = r_pend0 | ((r_state != ST_IDLE) & ~r_grant);
  assign w_busy1    = r_pend1 | ((r_state != ST_IDLE) &  r_grant);
  assign w_pick     = (r_pend0 & r_pend1) ? ~r_last : r_pend1;
  assign w_tmo_next = r_tmo + 16'd1;

  // NOTE: the 512-bit block register is reset along with everything else so
  // the data outputs read 0 after reset rather than a stale block.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state        <= ST_IDLE;
      r_pend0        <= 1'b0;
      r_pend1        <= 1'b0;
      r_cnt0         <= '0;
      r_cnt1         <= '0;
      r_non0         <= '0;
      r_non1         <= '0;
      r_grant        <= 1'b0;
      r_last         <= 1'b1;
      r_tmo          <= '0;
      r_core_req     <= 1'b0;
      r_core_counter <= '0;
      r_core_nonce   <= '0;
      r_data         <= '0;
      r_valid0       <= 1'b0;
      r_valid1       <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below sees the
      // pre-edge register values regardless of statement order.
      r_core_req <= 1'b0;
      r_valid0   <= 1'b0;
      r_valid1   <= 1'b0;
      r_error    <= 1'b0;

      if (bus.i_ch0_req && !w_busy0) begin
        r_pend0 <= 1'b1;
        r_cnt0  <= bus.i_ch0_counter;
        r_non0  <= bus.i_ch0_nonce;
      end
      if (bus.i_ch1_req && !w_busy1) begin
        r_pend1 <= 1'b1;
        r_cnt1  <= bus.i_ch1_counter;
        r_non1  <= bus.i_ch1_nonce;
      end

      case (r_state)
        ST_IDLE: begin
          if ((r_pend0 || r_pend1) && !bus.i_core_busy) begin
            r_grant        <= w_pick;
            r_last         <= w_pick;
            r_core_counter <= w_pick ? r_cnt1 : r_cnt0;
            r_core_nonce   <= w_pick ? r_non1 : r_non0;
            if (w_pick) r_pend1 <= 1'b0;
            else        r_pend0 <= 1'b0;
            r_core_req     <= 1'b1;
            r_state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_tmo   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.i_core_keystream_valid) begin
            r_data <= bus.i_core_keystream_data;
            if (r_grant) r_valid1 <= 1'b1;
            else         r_valid0 <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_tmo_next == TMO_LAST) begin
            // Error lands TIMEOUT_CYCLES cycles after the ISSUE cycle.
            r_error <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_tmo <= w_tmo_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ch0_busy            = w_busy0;
  assign bus.o_ch1_busy            = w_busy1;
  assign bus.o_ch0_keystream_data  = r_data;
  assign bus.o_ch1_keystream_data  = r_data;
  assign bus.o_ch0_keystream_valid = r_valid0;
  assign bus.o_ch1_keystream_valid = r_valid1;
  assign bus.o_core_req            = r_core_req;
  assign bus.o_core_counter        = r_core_counter;
  assign bus.o_core_nonce          = r_core_nonce;
  assign bus.o_error               = r_error;

endmodule

// File: tb/tb_chacha20_core_arbiter.sv
// Directed bench for chacha20_core_arbiter: a cycle-stepped driver with a
// small core responder that answers 4 cycles after each core request.
module tb_chacha20_core_arbiter;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chacha20_core_arbiter_if bus ();

  chacha20_core_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_aclk    (clk),
    .i_aresetn (rst_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit          auto_resp = 1'b1;
  bit          stray     = 1'b0;
  int          resp_due  = -1;
  logic [31:0] resp_cnt  = '0;

  int           req_q[$];
  int           req_cyc_q[$];
  int           order_q[$];
  int           val_cyc_q[$];
  int           v0_n = 0, v1_n = 0, err_n = 0;
  int           v0_cyc = -1, v1_cyc = -1, err_cyc = -1;
  logic [511:0] v0_data = '0, v1_data = '0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, observe at negedge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.i_ch0_req = 1'b0;
    bus.i_ch1_req = 1'b0;
    if (stray) begin
      bus.i_core_keystream_valid = 1'b1;
      bus.i_core_keystream_data  = {16{32'hBAD0BAD0}};
      stray = 1'b0;
    end else if (auto_resp && cyc == resp_due) begin
      bus.i_core_keystream_valid = 1'b1;
      bus.i_core_keystream_data  = {16{resp_cnt ^ 32'hC0DE0000}};
      resp_due = -1;
    end else begin
      bus.i_core_keystream_valid = 1'b0;
    end
    @(negedge clk);
    if (bus.o_core_req) begin
      req_q.push_back(int'(bus.o_core_counter));
      req_cyc_q.push_back(cyc);
      resp_cnt = bus.o_core_counter;
      resp_due = cyc + 4;
    end
    if (bus.o_ch0_keystream_valid) begin
      v0_n++; v0_cyc = cyc; v0_data = bus.o_ch0_keystream_data;
      order_q.push_back(0); val_cyc_q.push_back(cyc);
    end
    if (bus.o_ch1_keystream_valid) begin
      v1_n++; v1_cyc = cyc; v1_data = bus.o_ch1_keystream_data;
      order_q.push_back(1); val_cyc_q.push_back(cyc);
    end
    if (bus.o_error) begin
      err_n++; err_cyc = cyc;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while ((bus.o_ch0_busy || bus.o_ch1_busy) && n < budget);
    check(tag, 512'({bus.o_ch0_busy, bus.o_ch1_busy}), 512'(0));
  endtask

  task automatic clear_logs();
    req_q.delete(); req_cyc_q.delete(); order_q.delete(); val_cyc_q.delete();
  endtask

  task automatic pad_logs(input int n);
    while (req_q.size() < n)     req_q.push_back(-1);
    while (req_cyc_q.size() < n) req_cyc_q.push_back(-1);
    while (order_q.size() < n)   order_q.push_back(-1);
    while (val_cyc_q.size() < n) val_cyc_q.push_back(-1);
  endtask

  initial begin
    int c0, n, sz, v0p, v1p, ep;
    bit ok;

    bus.i_ch0_req = 1'b0; bus.i_ch0_counter = '0; bus.i_ch0_nonce = '0;
    bus.i_ch1_req = 1'b0; bus.i_ch1_counter = '0; bus.i_ch1_nonce = '0;
    bus.i_core_busy = 1'b0;
    bus.i_core_keystream_valid = 1'b0;
    bus.i_core_keystream_data  = '0;

    // Reset state
    repeat (3) step();
    check("rst_busy",    512'({bus.o_ch0_busy, bus.o_ch1_busy}), 512'(0));
    check("rst_valid",   512'({bus.o_ch0_keystream_valid, bus.o_ch1_keystream_valid}), 512'(0));
    check("rst_core",    512'({bus.o_core_req, bus.o_error}), 512'(0));
    check("rst_counter", 512'(bus.o_core_counter), 512'(0));
    check("rst_nonce",   512'(bus.o_core_nonce), 512'(0));
    check("rst_data",    bus.o_ch0_keystream_data, 512'(0));
    rst_n = 1'b1;
    step();

    // Contention twice: ch0 first after reset, then alternate
    clear_logs();
    bus.i_ch0_counter = 32'h10; bus.i_ch0_nonce = {12{8'h0C}}; bus.i_ch0_req = 1'b1;
    bus.i_ch1_counter = 32'h20; bus.i_ch1_nonce = {12{8'h1C}}; bus.i_ch1_req = 1'b1;
    wait_idle("t2_round1_done", 60);
    bus.i_ch0_counter = 32'h11; bus.i_ch0_req = 1'b1;
    bus.i_ch1_counter = 32'h21; bus.i_ch1_req = 1'b1;
    wait_idle("t2_round2_done", 60);
    sz = req_q.size();
    check("t2_req_count", 512'(sz), 512'(4));
    pad_logs(4);
    check("t2_req0_counter", 512'(req_q[0]), 512'(32'h10));
    check("t2_req1_counter", 512'(req_q[1]), 512'(32'h20));
    check("t2_req2_counter", 512'(req_q[2]), 512'(32'h11));
    check("t2_req3_counter", 512'(req_q[3]), 512'(32'h21));
    check("t2_order", 512'({order_q[0][1:0], order_q[1][1:0], order_q[2][1:0], order_q[3][1:0]}),
          512'(8'b00_01_00_01));
    check("t2_back_to_back", 512'(req_cyc_q[1]), 512'(val_cyc_q[0] + 1));
    check("t2_ch1_data", v1_data, {16{32'hC0DE0021}});
    check("t2_ch0_data", v0_data, {16{32'hC0DE0011}});

    // Single ch0 request, core answers 4 cycles after core_req
    clear_logs();
    v1p = v1_n; v0p = v0_n;
    c0 = cyc;
    bus.i_ch0_counter = 32'd5; bus.i_ch0_nonce = {12{8'hA5}}; bus.i_ch0_req = 1'b1;
    step();
    check("t1_busy_t1", 512'(bus.o_ch0_busy), 512'(1));
    check("t1_no_req_t1", 512'(bus.o_core_req), 512'(0));
    step();
    check("t1_core_req", 512'(bus.o_core_req), 512'(1));
    check("t1_counter", 512'(bus.o_core_counter), 512'(32'd5));
    check("t1_nonce", 512'(bus.o_core_nonce), 512'({12{8'hA5}}));
    ok = 1'b1; n = 0;
    while (v0_n == v0p && n < 20) begin
      if (bus.o_ch0_busy !== 1'b1) ok = 1'b0;
      step();
      n++;
    end
    check("t1_busy_held", 512'(ok), 512'(1));
    check("t1_valid_cycle", 512'(v0_cyc), 512'(c0 + 7));
    check("t1_busy_falls", 512'(bus.o_ch0_busy), 512'(0));
    check("t1_data", v0_data, {16{32'hC0DE0005}});
    check("t1_ch1_quiet", 512'(v1_n - v1p), 512'(0));
    step();

    // Duplicate ch0 request while pending is ignored
    clear_logs();
    bus.i_ch0_counter = 32'd7; bus.i_ch0_req = 1'b1;
    step();
    bus.i_ch0_counter = 32'd9; bus.i_ch0_req = 1'b1;
    wait_idle("t3_done", 40);
    sz = req_q.size();
    check("t3_req_count", 512'(sz), 512'(1));
    pad_logs(1);
    check("t3_counter", 512'(req_q[0]), 512'(32'd7));
    check("t3_data", v0_data, {16{32'hC0DE0007}});

    // Core busy stalls the grant of a pending ch1 request
    clear_logs();
    bus.i_core_busy = 1'b1;
    bus.i_ch1_counter = 32'h44; bus.i_ch1_req = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.o_core_req !== 1'b0 || bus.o_ch1_busy !== 1'b1) ok = 1'b0;
    end
    check("t4_stall_held", 512'(ok), 512'(1));
    bus.i_core_busy = 1'b0;
    step();
    check("t4_req_after_drop", 512'(bus.o_core_req), 512'(1));
    check("t4_counter", 512'(bus.o_core_counter), 512'(32'h44));
    wait_idle("t4_done", 40);
    check("t4_data", v1_data, {16{32'hC0DE0044}});

    // Core never answers: timeout abort, then a stray valid is ignored
    clear_logs();
    auto_resp = 1'b0;
    v0p = v0_n; v1p = v1_n; ep = err_n;
    c0 = cyc;
    bus.i_ch0_counter = 32'h55; bus.i_ch0_req = 1'b1;
    step();
    step();
    check("t5_core_req", 512'(bus.o_core_req), 512'(1));
    ok = 1'b1; n = 0;
    while (err_n == ep && n < 20) begin
      if (bus.o_ch0_busy !== 1'b1) ok = 1'b0;
      step();
      n++;
    end
    check("t5_busy_until_abort", 512'(ok), 512'(1));
    check("t5_error_cycle", 512'(err_cyc), 512'(c0 + 2 + TMO));
    check("t5_busy_falls", 512'(bus.o_ch0_busy), 512'(0));
    step();
    check("t5_error_pulse", 512'(bus.o_error), 512'(0));
    stray = 1'b1;
    repeat (3) step();
    check("t5_error_once", 512'(err_n - ep), 512'(1));
    check("t5_no_delivery", 512'({16'(v0_n - v0p), 16'(v1_n - v1p)}), 512'(0));
    auto_resp = 1'b1;

    // Asynchronous reset while waiting on the core
    auto_resp = 1'b0;
    bus.i_ch0_counter = 32'h66; bus.i_ch0_req = 1'b1;
    repeat (4) step();
    check("t6_pre_busy", 512'(bus.o_ch0_busy), 512'(1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",    512'({bus.o_ch0_busy, bus.o_ch1_busy}), 512'(0));
    check("t6_rst_counter", 512'(bus.o_core_counter), 512'(0));
    check("t6_rst_nonce",   512'(bus.o_core_nonce), 512'(0));
    check("t6_rst_data",    bus.o_ch1_keystream_data, 512'(0));
    check("t6_rst_misc",    512'({bus.o_core_req, bus.o_error,
                                  bus.o_ch0_keystream_valid, bus.o_ch1_keystream_valid}), 512'(0));
    repeat (2) step();
    rst_n = 1'b1;
    resp_due = -1;
    auto_resp = 1'b1;
    step();
    check("t6_post_idle", 512'({bus.o_ch0_busy, bus.o_ch1_busy}), 512'(0));
    clear_logs();
    bus.i_ch1_counter = 32'h77; bus.i_ch1_req = 1'b1;
    wait_idle("t6_ch1_done", 40);
    pad_logs(1);
    check("t6_ch1_counter", 512'(req_q[0]), 512'(32'h77));
    check("t6_ch1_data", v1_data, {16{32'hC0DE0077}});
    clear_logs();
    bus.i_ch0_counter = 32'h30; bus.i_ch0_req = 1'b1;
    bus.i_ch1_counter = 32'h31; bus.i_ch1_req = 1'b1;
    wait_idle("t6_pair_done", 60);
    pad_logs(2);
    check("t6_order", 512'({order_q[0][1:0], order_q[1][1:0]}), 512'(4'b00_01));
    check("t6_first_counter", 512'(req_q[0]), 512'(32'h30));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
